data_fetcher: RTL and testbench

DATA_FETCHER -- requirements
Module: data_fetcher

---
 rtl/data_pkg.sv | 21 ++
 rtl/sample_fifo.sv | 57 +++++
 rtl/data_fetcher.sv | 147 ++++++++++++++
 tb/tb_data_fetcher.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_pkg.sv
// Shared types and sizing helpers for the data fetcher.
package data_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAIN  = 3'd4
    } fetch_state_t;

    function automatic int calc_x_width(input int pieces, input int bram_width);
        return pieces * bram_width;
    endfunction

    // A single-slot medium still needs a one-bit address.
    function automatic int calc_addr_size(input int addrs);
        return (addrs > 1) ? $clog2(addrs) : 1;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Two-entry FIFO holding fetched samples until downstream takes them.
module sample_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'd2);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage, pointers and occupancy; flush drops contents without clearing storage.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_fetcher.sv
// Walks a run of sample addresses through the data medium and streams the
// results downstream through a two-entry buffer.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for start_in
//   ST_ISSUE  | addr_out just changed, held for one cycle
//   ST_SETTLE | finished_in may still refer to the old address, ignored
//   ST_WAIT   | push the sample once finished_in and buffer has room
//   ST_DRAIN  | all samples pushed, wait for downstream to empty buffer
module data_fetcher
    import data_pkg::*;
#(
    parameter int  ADDRS      = 1024,
    parameter int  BRAM_WIDTH = 64,
    parameter int  PIECES     = 16,
    localparam int ADDR_SIZE  = calc_addr_size(ADDRS),
    localparam int X_WIDTH    = calc_x_width(PIECES, BRAM_WIDTH)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [ADDR_SIZE-1:0] base_addr_in,
    input  logic [ADDR_SIZE:0]   count_in,
    input  logic                 abort_in,
    output logic [ADDR_SIZE-1:0] addr_out,
    input  logic [X_WIDTH-1:0]   x_in,
    input  logic [X_WIDTH-1:0]   y_in,
    input  logic                 finished_in,
    output logic                 sample_valid_out,
    input  logic                 sample_ready_in,
    output logic [X_WIDTH-1:0]   x_out,
    output logic [X_WIDTH-1:0]   y_out,
    output logic [ADDR_SIZE-1:0] index_out,
    output logic                 last_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int                   ENTRY_W   = 2 * X_WIDTH + ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE:0]   MAX_COUNT = (ADDR_SIZE + 1)'(ADDRS);
    localparam logic [ADDR_SIZE:0]   ONE_LEFT  = (ADDR_SIZE + 1)'(1);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(ADDRS - 1);

    fetch_state_t         state, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ADDR_SIZE:0]   remaining, remaining_d;
    logic                 done_q, done_d;
    logic [ADDR_SIZE:0]   count_clamped;
    logic [ADDR_SIZE-1:0] next_addr;
    logic                 fifo_push, fifo_pop, fifo_flush;
    logic                 fifo_empty, fifo_full;
    logic [ENTRY_W-1:0]   fifo_wr, fifo_rd;

    assign count_clamped = (count_in > MAX_COUNT) ? MAX_COUNT : count_in;
    // Explicit wrap so non-power-of-two ADDRS never leaves the valid range.
    assign next_addr     = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    assign fifo_wr       = {x_in, y_in, addr_q, (remaining == ONE_LEFT)};
    assign fifo_pop      = !fifo_empty && sample_ready_in;

    assign addr_out         = addr_q;
    assign sample_valid_out = !fifo_empty;
    assign {x_out, y_out, index_out, last_out} = fifo_rd;
    assign done_out         = done_q;
    // done_q is only ever set on the way into IDLE, so this covers the done cycle.
    assign busy_out         = (state != ST_IDLE) || done_q;

    // State, address, run counter and done pulse registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            remaining <= remaining_d;
            done_q    <= done_d;
        end
    end

    // Next-state, address stepping, buffer push and abort handling.
    always_comb begin
        state_d     = state;
        addr_d      = addr_q;
        remaining_d = remaining;
        done_d      = 1'b0;
        fifo_push   = 1'b0;
        fifo_flush  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_in && !done_q) begin
                    remaining_d = count_clamped;
                    if (count_clamped == '0) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d  = base_addr_in;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (finished_in && !fifo_full) begin
                    fifo_push   = 1'b1;
                    remaining_d = remaining - ONE_LEFT;
                    if (remaining != ONE_LEFT) begin
                        addr_d  = next_addr;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_in && state != ST_IDLE) begin
            fifo_push  = 1'b0;
            fifo_flush = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
        end
    end

    sample_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (fifo_flush),
        .wr_data (fifo_wr),
        .rd_data (fifo_rd),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_data_fetcher.sv
// Scoreboard bench for data_fetcher with a simple data-medium model.
module tb_data_fetcher;

    localparam int ADDRS  = 1024;
    localparam int BW     = 64;
    localparam int PIECES = 16;
    localparam int AW     = 10;
    localparam int XW     = PIECES * BW;

    typedef struct {
        logic [AW-1:0] idx;
        logic          last;
    } exp_t;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start_in;
    logic [AW-1:0] base_addr_in;
    logic [AW:0]   count_in;
    logic          abort_in;
    logic [AW-1:0] addr_out;
    logic [XW-1:0] x_in, y_in;
    logic          finished_in;
    logic          sample_valid_out;
    logic          sample_ready_in;
    logic [XW-1:0] x_out, y_out;
    logic [AW-1:0] index_out;
    logic          last_out;
    logic          busy_out;
    logic          done_out;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    logic [AW-1:0] med_addr = '0;
    int            med_cnt  = 0;

    always #5 clk_in = ~clk_in;

    data_fetcher #(
        .ADDRS      (ADDRS),
        .BRAM_WIDTH (BW),
        .PIECES     (PIECES)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .start_in         (start_in),
        .base_addr_in     (base_addr_in),
        .count_in         (count_in),
        .abort_in         (abort_in),
        .addr_out         (addr_out),
        .x_in             (x_in),
        .y_in             (y_in),
        .finished_in      (finished_in),
        .sample_valid_out (sample_valid_out),
        .sample_ready_in  (sample_ready_in),
        .x_out            (x_out),
        .y_out            (y_out),
        .index_out        (index_out),
        .last_out         (last_out),
        .busy_out         (busy_out),
        .done_out         (done_out)
    );

    function automatic logic [XW-1:0] mk_x(input logic [AW-1:0] a);
        logic [XW-1:0] r;
        for (int i = 0; i < PIECES; i++)
            r[i*BW +: BW] = {32'hD00D0000 | 32'(a), 32'(i) ^ 32'h5A5A0000};
        return r;
    endfunction

    function automatic logic [XW-1:0] mk_y(input logic [AW-1:0] a);
        logic [XW-1:0] r;
        for (int i = 0; i < PIECES; i++)
            r[i*BW +: BW] = {32'(i) * 32'h01010101, 22'h2AAAAA, a};
        return r;
    endfunction

    // Data medium: result for an address becomes valid two edges after it changes.
    always @(posedge clk_in) begin
        #1;
        if (addr_out !== med_addr) begin
            med_addr = addr_out;
            med_cnt  = 0;
        end else if (med_cnt < 3) begin
            med_cnt++;
        end
        finished_in = (med_cnt >= 2);
        x_in        = mk_x(med_addr);
        y_in        = mk_y(med_addr);
    end

    // Pulses start for one cycle and queues the samples the run must produce.
    task automatic start_run(input int base, input int cnt, input bit with_abort);
        int   n;
        exp_t e;
        @(negedge clk_in);
        base_addr_in = AW'(base);
        count_in     = (AW + 1)'(cnt);
        start_in     = 1'b1;
        abort_in     = with_abort;
        @(negedge clk_in);
        start_in = 1'b0;
        abort_in = 1'b0;
        n = (cnt > ADDRS) ? ADDRS : cnt;
        for (int i = 0; i < n; i++) begin
            e.idx  = AW'((base + i) % ADDRS);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1; start_in = 1'b0; abort_in = 1'b0; sample_ready_in = 1'b0;
        base_addr_in = '0; count_in = '0; finished_in = 1'b0; x_in = '0; y_in = '0;
        #12;
        n_cmp++;
        if (addr_out !== '0 || sample_valid_out !== 1'b0 || x_out !== '0 || y_out !== '0 ||
            index_out !== '0 || last_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: addr=%0d valid=%0b index=%0d last=%0b busy=%0b done=%0b, expected all zero",
                     addr_out, sample_valid_out, index_out, last_out, busy_out, done_out);
        end
        @(negedge clk_in);
        rst_in = 1'b0;
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        n_cmp++;
        if (busy_out !== 1'b0 || done_out !== 1'b0) begin
            n_err++;
            $display("FAIL idle_abort: busy=%0b done=%0b, expected 0 0", busy_out, done_out);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   done_cnt = 0;
        int   first_valid = -1;
        sample_ready_in = 1'b1;
        start_run(5, 3, 1'b0);
        n_cmp++;
        if (busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy_start: busy=%0b, expected 1", busy_out);
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_in);
            if (sample_valid_out && first_valid < 0) first_valid = k;
            if (sample_valid_out && sample_ready_in) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL basic_extra: got index=%0d, expected no sample", index_out);
                end else begin
                    e = sb.pop_front();
                    if (index_out !== e.idx || last_out !== e.last || x_out !== mk_x(e.idx) || y_out !== mk_y(e.idx)) begin
                        n_err++;
                        $display("FAIL basic_sample: got index=%0d last=%0b, expected index=%0d last=%0b", index_out, last_out, e.idx, e.last);
                    end
                end
            end
            if (done_out) begin
                done_cnt++;
                n_cmp++;
                if (busy_out !== 1'b1) begin
                    n_err++;
                    $display("FAIL basic_busy_done: busy=%0b in done cycle, expected 1", busy_out);
                end
            end
            start_in     = (k == 6);
            base_addr_in = AW'(500);
            count_in     = (AW + 1)'(5);
        end
        start_in = 1'b0;
        n_cmp++;
        if (first_valid !== 3) begin
            n_err++;
            $display("FAIL basic_latency: first valid at check %0d, expected 3", first_valid);
        end
        n_cmp++;
        if (sb.size() != 0 || done_cnt != 1 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL basic_end: left=%0d done_pulses=%0d busy=%0b, expected 0 1 0", sb.size(), done_cnt, busy_out);
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        int   done_cnt = 0;
        sample_ready_in = 1'b1;
        start_run(ADDRS - 2, 4, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk_in);
            if (sample_valid_out && sample_ready_in) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL wrap_extra: got index=%0d, expected no sample", index_out);
                end else begin
                    e = sb.pop_front();
                    if (index_out !== e.idx || last_out !== e.last || x_out !== mk_x(e.idx) || y_out !== mk_y(e.idx)) begin
                        n_err++;
                        $display("FAIL wrap_sample: got index=%0d last=%0b, expected index=%0d last=%0b", index_out, last_out, e.idx, e.last);
                    end
                end
            end
            if (done_out) done_cnt++;
        end
        n_cmp++;
        if (sb.size() != 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL wrap_end: left=%0d done_pulses=%0d, expected 0 1", sb.size(), done_cnt);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   done_cnt = 0;
        int   delivered = 0;
        sample_ready_in = 1'b0;
        start_run(5, 3, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            if (sample_valid_out) begin
                n_cmp++;
                if (index_out !== AW'(5) || last_out !== 1'b0 || x_out !== mk_x(AW'(5))) begin
                    n_err++;
                    $display("FAIL bp_hold: index=%0d last=%0b while stalled, expected 5 0", index_out, last_out);
                end
            end
        end
        n_cmp++;
        if (sample_valid_out !== 1'b1 || addr_out !== AW'(7)) begin
            n_err++;
            $display("FAIL bp_wait: valid=%0b addr=%0d, expected 1 7", sample_valid_out, addr_out);
        end
        sample_ready_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk_in);
            if (sample_valid_out && sample_ready_in) begin
                n_cmp++;
                delivered++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: got index=%0d, expected no sample", index_out);
                end else begin
                    e = sb.pop_front();
                    if (index_out !== e.idx || last_out !== e.last || x_out !== mk_x(e.idx) || y_out !== mk_y(e.idx)) begin
                        n_err++;
                        $display("FAIL bp_sample: got index=%0d last=%0b, expected index=%0d last=%0b", index_out, last_out, e.idx, e.last);
                    end
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (delivered != 3) begin
                    n_err++;
                    $display("FAIL bp_burst: %0d samples in first 3 cycles, expected 3", delivered);
                end
            end
            if (done_out) done_cnt++;
        end
        n_cmp++;
        if (sb.size() != 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL bp_end: left=%0d done_pulses=%0d, expected 0 1", sb.size(), done_cnt);
        end
    endtask

    task automatic test_zero_count();
        int done_at = -1;
        int done_cnt = 0;
        int valid_seen = 0;
        sample_ready_in = 1'b1;
        start_run(9, 0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            if (sample_valid_out) valid_seen++;
            if (done_out) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
        end
        n_cmp++;
        if (valid_seen != 0 || done_cnt != 1 || done_at < 1 || done_at > 2 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL zero_count: valid_cycles=%0d done_pulses=%0d done_at=%0d busy=%0b, expected 0 1 1..2 0",
                     valid_seen, done_cnt, done_at, busy_out);
        end
    endtask

    task automatic test_abort();
        exp_t e;
        int   got = 0;
        int   done_cnt = 0;
        sample_ready_in = 1'b1;
        start_run(100, 10, 1'b0);
        for (int k = 1; k <= 20 && got == 0; k++) begin
            @(negedge clk_in);
            if (sample_valid_out && sample_ready_in) begin
                n_cmp++;
                got = 1;
                e = sb.pop_front();
                if (index_out !== e.idx || last_out !== e.last || x_out !== mk_x(e.idx)) begin
                    n_err++;
                    $display("FAIL abort_first: got index=%0d last=%0b, expected index=%0d last=%0b", index_out, last_out, e.idx, e.last);
                end
            end
        end
        n_cmp++;
        if (got == 0) begin
            n_err++;
            $display("FAIL abort_timeout: no sample within 20 cycles, expected one");
        end
        @(negedge clk_in);
        sample_ready_in = 1'b0;
        repeat (8) @(negedge clk_in);
        n_cmp++;
        if (sample_valid_out !== 1'b1 || index_out !== AW'(101)) begin
            n_err++;
            $display("FAIL abort_pre: valid=%0b index=%0d, expected 1 101", sample_valid_out, index_out);
        end
        abort_in = 1'b1;
        @(negedge clk_in);
        abort_in = 1'b0;
        sb.delete();
        n_cmp++;
        if (sample_valid_out !== 1'b0 || done_out !== 1'b1 || busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL abort_next: valid=%0b done=%0b busy=%0b, expected 0 1 1", sample_valid_out, done_out, busy_out);
        end
        @(negedge clk_in);
        n_cmp++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            n_err++;
            $display("FAIL abort_after: done=%0b busy=%0b, expected 0 0", done_out, busy_out);
        end
        sample_ready_in = 1'b1;
        start_run(200, 1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk_in);
            if (sample_valid_out && sample_ready_in) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL restart_extra: got index=%0d, expected no sample", index_out);
                end else begin
                    e = sb.pop_front();
                    if (index_out !== e.idx || last_out !== e.last || y_out !== mk_y(e.idx)) begin
                        n_err++;
                        $display("FAIL restart_sample: got index=%0d last=%0b, expected index=%0d last=%0b", index_out, last_out, e.idx, e.last);
                    end
                end
            end
            if (done_out) done_cnt++;
        end
        n_cmp++;
        if (sb.size() != 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL restart_end: left=%0d done_pulses=%0d, expected 0 1", sb.size(), done_cnt);
        end
    endtask

    task automatic test_async_reset();
        int done_cnt = 0;
        int valid_cnt = 0;
        sample_ready_in = 1'b0;
        start_run(5, 3, 1'b0);
        repeat (12) @(negedge clk_in);
        n_cmp++;
        if (sample_valid_out !== 1'b1 || busy_out !== 1'b1) begin
            n_err++;
            $display("FAIL arst_pre: valid=%0b busy=%0b, expected 1 1", sample_valid_out, busy_out);
        end
        #2;
        rst_in = 1'b1;
        #1;
        n_cmp++;
        if (addr_out !== '0 || sample_valid_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0 ||
            index_out !== '0 || last_out !== 1'b0 || x_out !== '0 || y_out !== '0) begin
            n_err++;
            $display("FAIL arst_outputs: addr=%0d valid=%0b busy=%0b done=%0b index=%0d last=%0b, expected all zero",
                     addr_out, sample_valid_out, busy_out, done_out, index_out, last_out);
        end
        sb.delete();
        @(negedge clk_in);
        rst_in = 1'b0;
        sample_ready_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_in);
            if (done_out) done_cnt++;
            if (sample_valid_out) valid_cnt++;
        end
        n_cmp++;
        if (done_cnt != 0 || valid_cnt != 0) begin
            n_err++;
            $display("FAIL arst_after: done_pulses=%0d valid_cycles=%0d, expected 0 0", done_cnt, valid_cnt);
        end
    endtask

    task automatic test_clamp();
        exp_t e;
        int   done_cnt = 0;
        sample_ready_in = 1'b1;
        start_run(0, 2000, 1'b0);
        for (int k = 1; k <= 4300 && done_cnt == 0; k++) begin
            @(negedge clk_in);
            if (sample_valid_out && sample_ready_in) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL clamp_extra: got index=%0d, expected no sample", index_out);
                end else begin
                    e = sb.pop_front();
                    if (index_out !== e.idx || last_out !== e.last) begin
                        n_err++;
                        $display("FAIL clamp_sample: got index=%0d last=%0b, expected index=%0d last=%0b", index_out, last_out, e.idx, e.last);
                    end
                end
            end
            if (done_out) done_cnt++;
        end
        n_cmp++;
        if (sb.size() != 0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL clamp_end: left=%0d done_pulses=%0d, expected 0 1", sb.size(), done_cnt);
        end
        sb.delete();
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_abort();
        test_async_reset();
        test_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
